// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: sequential AES InvSubBytes, BYTES_PER_CYCLE bytes per busy cycle; ports clk/reset, in_valid/in_ready/in_data, out_valid/out_ready/out_data, busy
module inv_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int B = BYTES_PER_CYCLE;
  localparam int STEPS = 16 / B;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  if (!(B == 1 || B == 2 || B == 4 || B == 8 || B == 16)) begin : g_bad_param
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [127:0] work, work_nxt, sub;
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[2040 - 8 * int'(x) +: 8];
  endfunction
  // byte 0 sits in the top bits, so lane k*B+j lives at bit 127-8*(k*B+j)
  always_comb begin
    sub = work;
    for (int j = 0; j < B; j++) begin
      sub[127 - 8 * (int'(cnt) * B + j) -: 8] = inv_sbox(work[127 - 8 * (int'(cnt) * B + j) -: 8]);
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    work_nxt = work;
    if (state == IDLE && in_valid) begin
      state_nxt = BUSY;
      cnt_nxt = '0;
      work_nxt = in_data;
    end else if (state == BUSY) begin
      work_nxt = sub;
      cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
      state_nxt = (cnt == LAST) ? DONE : BUSY;
    end else if (state == DONE && out_ready) begin
      state_nxt = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      work <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      work <= work_nxt;
    end
  end
  assign in_ready = state == IDLE;
  assign busy = state == BUSY;
  assign out_valid = state == DONE;
  assign out_data = out_valid ? work : '0;
endmodule
